// File: rtl/tetris_input_pkg.sv
// Shared encodings and timing defaults for the controller-to-move-command path.
// Button codes follow the controller decoder; commands follow the game core.
package tetris_input_pkg;

    localparam int unsigned CNT_W             = 5;
    localparam int unsigned DAS_DELAY_DEFAULT = 16;
    localparam int unsigned DAS_RATE_DEFAULT  = 6;
    localparam int unsigned SOFT_RATE_DEFAULT = 2;

    localparam logic [3:0] BTN_NONE   = 4'd0;
    localparam logic [3:0] BTN_A      = 4'd1;
    localparam logic [3:0] BTN_B      = 4'd2;
    localparam logic [3:0] BTN_SELECT = 4'd3;
    localparam logic [3:0] BTN_START  = 4'd4;
    localparam logic [3:0] BTN_UP     = 4'd5;
    localparam logic [3:0] BTN_DOWN   = 4'd6;
    localparam logic [3:0] BTN_LEFT   = 4'd7;
    localparam logic [3:0] BTN_RIGHT  = 4'd8;

    typedef enum logic [2:0] {
        CMD_LEFT      = 3'd0,
        CMD_RIGHT     = 3'd1,
        CMD_SOFT_DROP = 3'd2,
        CMD_HARD_DROP = 3'd3,
        CMD_ROT_CW    = 3'd4,
        CMD_ROT_CCW   = 3'd5,
        CMD_PAUSE     = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Select and out-of-range codes carry no game meaning and read as no button.
    function automatic logic [3:0] sanitize_code(input logic [3:0] code);
        if (code > BTN_RIGHT || code == BTN_SELECT) begin
            return BTN_NONE;
        end
        return code;
    endfunction

    function automatic cmd_e map_cmd(input logic [3:0] code);
        case (code)
            BTN_A:     return CMD_ROT_CW;
            BTN_B:     return CMD_ROT_CCW;
            BTN_START: return CMD_PAUSE;
            BTN_UP:    return CMD_HARD_DROP;
            BTN_DOWN:  return CMD_SOFT_DROP;
            BTN_RIGHT: return CMD_RIGHT;
            default:   return CMD_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/das_timer.sv
// Saturating frame counter with terminal-count compare; expire is combinational
// on an advancing frame and clears the count on the same edge.
module das_timer
    import tetris_input_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        expire    = advance && !clear && (count_inc == limit);
        count_d   = count_q;
        if (clear || expire) begin
            count_d = '0;
        end else if (advance) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/move_command_gen.sv
// Turns per-frame controller codes into move commands with DAS auto-repeat.
// Commands appear one cycle after frame_tick; a command arriving while one is stalled is dropped.
module move_command_gen
    import tetris_input_pkg::*;
#(
    parameter int unsigned DAS_DELAY = DAS_DELAY_DEFAULT,
    parameter int unsigned DAS_RATE  = DAS_RATE_DEFAULT,
    parameter int unsigned SOFT_RATE = SOFT_RATE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] button_code,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       cmd_dropped
);

    logic [3:0] cur_q, cur_d;
    rpt_state_e state_q, state_d;
    logic       cmd_valid_q, cmd_valid_d;
    cmd_e       cmd_q, cmd_d;
    logic       cmd_dropped_q, cmd_dropped_d;

    logic [3:0]       code_s;
    logic             press;
    logic             held;
    logic             gen_vld;
    cmd_e             gen_cmd;
    logic             tmr_clear;
    logic             tmr_advance;
    logic             tmr_expire;
    logic [CNT_W-1:0] tmr_limit;

    // cur_q doubles as "prev" for the next frame's edge detection.
    assign code_s      = sanitize_code(button_code);
    assign press       = frame_tick && (code_s != BTN_NONE) && (code_s != cur_q);
    assign held        = frame_tick && (code_s != BTN_NONE) && (code_s == cur_q);
    assign tmr_clear   = frame_tick && !held;
    assign tmr_advance = held && (state_q != ST_IDLE);
    assign tmr_limit   = (state_q == ST_DELAY) ? CNT_W'(DAS_DELAY) :
                         (cur_q == BTN_DOWN)   ? CNT_W'(SOFT_RATE) : CNT_W'(DAS_RATE);

    das_timer u_das_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .advance (tmr_advance),
        .limit   (tmr_limit),
        .expire  (tmr_expire)
    );

    always_comb begin
        cur_d         = frame_tick ? code_s : cur_q;
        state_d       = state_q;
        gen_vld       = 1'b0;
        gen_cmd       = map_cmd(code_s);
        cmd_valid_d   = cmd_valid_q;
        cmd_d         = cmd_q;
        cmd_dropped_d = 1'b0;

        if (frame_tick) begin
            if (code_s == BTN_NONE) begin
                state_d = ST_IDLE;
            end else if (press) begin
                gen_vld = 1'b1;
                case (code_s)
                    BTN_LEFT, BTN_RIGHT: state_d = ST_DELAY;
                    BTN_DOWN:            state_d = ST_REPEAT;
                    default:             state_d = ST_IDLE;
                endcase
            end else if (tmr_expire) begin
                gen_vld = 1'b1;
                state_d = ST_REPEAT;
            end
        end

        // Acceptance and a new load may coincide; only a stall causes a drop.
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (gen_vld) begin
            if (cmd_valid_q && !cmd_ready) begin
                cmd_dropped_d = 1'b1;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_d       = gen_cmd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q         <= BTN_NONE;
            state_q       <= ST_IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= CMD_LEFT;
            cmd_dropped_q <= 1'b0;
        end else begin
            cur_q         <= cur_d;
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
            cmd_dropped_q <= cmd_dropped_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd         = cmd_q;
    assign cmd_dropped = cmd_dropped_q;

endmodule

// File: tb/tb_move_command_gen.sv
// Bench for move_command_gen: directed DAS scenarios plus randomized hold/release
// traffic, every cycle compared against a hold-count reference model.
module tb_move_command_gen;

    localparam int D_DELAY = 16;
    localparam int D_RATE  = 6;
    localparam int S_RATE  = 2;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [3:0] button_code;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_dropped;

    move_command_gen dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .button_code (button_code),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_dropped (cmd_dropped)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model state: expected outputs plus hold tracking.
    logic       exp_valid;
    logic [2:0] exp_cmd;
    logic       exp_drop;
    int         m_prev;
    int         m_n;
    int         cmd_map [0:15];

    int          ready_mode;
    int          frame_idx;
    int          acc_cnt;
    int          drop_cnt;
    logic [63:0] acc_mask;
    logic [2:0]  last_cmd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int emits(input int c, input int n);
        if (n == 0) return 1;
        if (c == 7 || c == 8) return int'(n == D_DELAY || (n > D_DELAY && (n - D_DELAY) % D_RATE == 0));
        if (c == 6) return int'(n % S_RATE == 0);
        return 0;
    endfunction

    task automatic model_update(input logic tk, input logic [3:0] code, input logic rdy, input logic rst);
        int c;
        int gen;
        if (rst) begin
            exp_valid = 1'b0; exp_cmd = 3'd0; exp_drop = 1'b0; m_prev = 0; m_n = 0;
            return;
        end
        gen = 0;
        c = 0;
        exp_drop = 1'b0;
        if (tk) begin
            c = (code > 4'd8 || code == 4'd3) ? 0 : int'(code);
            if (c == 0) m_n = 0;
            else if (c != m_prev) begin m_n = 0; gen = 1; end
            else begin m_n++; gen = emits(c, m_n); end
            m_prev = c;
        end
        if (gen != 0 && exp_valid && !rdy) begin
            exp_drop = 1'b1;
        end else begin
            if (exp_valid && rdy) exp_valid = 1'b0;
            if (gen != 0) begin exp_valid = 1'b1; exp_cmd = 3'(cmd_map[c]); end
        end
    endtask

    task automatic step(input logic tk, input logic [3:0] code, input logic rst);
        logic rdy;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
        frame_tick = tk; button_code = code; cmd_ready = rdy; reset = rst;
        if (!rst && cmd_valid && rdy) begin
            acc_cnt++;
            last_cmd = cmd;
            if (frame_idx < 64) acc_mask[frame_idx] = 1'b1;
        end
        @(posedge clk);
        model_update(tk, code, rdy, rst);
        @(negedge clk);
        chk("valid", {63'd0, cmd_valid}, {63'd0, exp_valid});
        chk("cmd", {61'd0, cmd}, {61'd0, exp_cmd});
        chk("dropped", {63'd0, cmd_dropped}, {63'd0, exp_drop});
        if (cmd_dropped) drop_cnt++;
    endtask

    task automatic frame(input logic [3:0] code, input int gap);
        step(1'b1, code, 1'b0);
        for (int g = 0; g < gap; g++) step(1'b0, code, 1'b0);
        frame_idx++;
    endtask

    task automatic frames(input logic [3:0] code, input int count);
        for (int f = 0; f < count; f++) frame(code, 3);
    endtask

    task automatic clear_stats();
        acc_cnt = 0; drop_cnt = 0; acc_mask = '0; frame_idx = 0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; frame_tick = 1'b0; button_code = 4'd0; cmd_ready = 1'b0;
        checks = 0; errors = 0; ready_mode = 0;
        exp_valid = 1'b0; exp_cmd = 3'd0; exp_drop = 1'b0; m_prev = 0; m_n = 0;
        last_cmd = 3'd0;
        for (int i = 0; i < 16; i++) cmd_map[i] = 0;
        cmd_map[1] = 4; cmd_map[2] = 5; cmd_map[4] = 6; cmd_map[5] = 3;
        cmd_map[6] = 2; cmd_map[7] = 0; cmd_map[8] = 1;
        clear_stats();

        @(negedge clk);
        step(1'b1, 4'd7, 1'b1);
        step(1'b0, 4'd7, 1'b1);
        chk("reset_valid", {63'd0, cmd_valid}, 64'd0);
        chk("reset_cmd", {61'd0, cmd}, 64'd0);

        // Left held 30 frames.
        clear_stats();
        frames(4'd7, 30); frames(4'd0, 2);
        chk("left_hold_mask", acc_mask, 64'h1041_0001);
        chk("left_hold_cnt", acc_cnt, 4);

        // Down held 7 frames.
        clear_stats();
        frames(4'd6, 7); frames(4'd0, 2);
        chk("down_hold_mask", acc_mask, 64'h55);

        // A held, released, pressed again.
        clear_stats();
        frames(4'd1, 10); frames(4'd0, 1); frames(4'd1, 3); frames(4'd0, 2);
        chk("a_repress_cnt", acc_cnt, 2);
        chk("a_last_cmd", {61'd0, last_cmd}, 64'd4);

        // Stalled consumer: Up then B.
        clear_stats();
        ready_mode = 2;
        frames(4'd5, 1); frames(4'd2, 1);
        chk("stall_drop_cnt", drop_cnt, 1);
        ready_mode = 0;
        frames(4'd2, 3); frames(4'd0, 2);
        chk("stall_acc_cnt", acc_cnt, 1);
        chk("stall_acc_cmd", {61'd0, last_cmd}, 64'd3);

        // Left then direct change to Right.
        clear_stats();
        frames(4'd7, 10); frames(4'd8, 17); frames(4'd0, 2);
        chk("left_to_right_mask", acc_mask, 64'h400_0401);

        // Reset mid-hold with a pending command.
        clear_stats();
        frames(4'd8, 16);
        ready_mode = 2;
        frames(4'd8, 2);
        chk("pre_reset_valid", {63'd0, cmd_valid}, 64'd1);
        step(1'b1, 4'd8, 1'b1);
        chk("post_reset_valid", {63'd0, cmd_valid}, 64'd0);
        clear_stats();
        ready_mode = 0;
        frames(4'd8, 4);
        chk("post_reset_mask", acc_mask, 64'h1);
        frames(4'd0, 2);

        // Randomized holds, gaps, backpressure and occasional resets.
        for (int k = 0; k < 150; k++) begin
            logic [3:0] code;
            int len;
            code = 4'($urandom_range(0, 15));
            len = int'($urandom_range(1, 40));
            ready_mode = int'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) frame(code, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 19) == 0) step(1'($urandom_range(0, 1)), code, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_command_gen.md
MOVE_COMMAND_GEN -- requirements
Module: move_command_gen

Interface
REQ-001 The block SHALL have parameter DAS_DELAY, default 16, giving the number of frames a Left/Right press is held before auto-repeat starts (legal range 1..31).
REQ-002 The block SHALL have parameter DAS_RATE, default 6, giving the number of frames between Left/Right auto-repeats (legal range 1..31).
REQ-003 The block SHALL have parameter SOFT_RATE, default 2, giving the number of frames between Down repeats (legal range 1..31).
REQ-004 The block SHALL have port clk, input, width 1: the single 40 MHz system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port frame_tick, input, width 1: one-cycle 60 Hz strobe; button_code is sampled only on this strobe.
REQ-007 The block SHALL have port button_code, input, width 4: controller code, where 0 = none, 1 = A, 2 = B, 3 = Select, 4 = Start, 5 = Up, 6 = Down, 7 = Left, 8 = Right.
REQ-008 The block SHALL have port cmd_ready, input, width 1: the consumer accepts the command when cmd_ready and cmd_valid are both high.
REQ-009 The block SHALL have port cmd_valid, output, width 1: a command is pending.
REQ-010 The block SHALL have port cmd, output, width 3: 0 = LEFT, 1 = RIGHT, 2 = SOFT_DROP, 3 = HARD_DROP, 4 = ROT_CW, 5 = ROT_CCW, 6 = PAUSE.
REQ-011 The block SHALL have port cmd_dropped, output, width 1: one-cycle pulse when a generated command is discarded.

Function
REQ-012 On each frame_tick the block SHALL register button_code as cur; codes 9..15 and 3 (Select) SHALL be treated as 0.
REQ-013 A press event SHALL occur when cur is nonzero and cur differs from the code registered at the previous frame_tick (prev).
REQ-014 On a press event the block SHALL generate the mapped command: A -> ROT_CW, B -> ROT_CCW, Start -> PAUSE, Up -> HARD_DROP, Down -> SOFT_DROP, Left -> LEFT, Right -> RIGHT.
REQ-015 Repeat FSM states SHALL be IDLE, DELAY and REPEAT, with a 5-bit frame counter.
REQ-016 On a press of Left or Right the FSM SHALL enter DELAY with the counter at 0; on a press of Down it SHALL enter REPEAT with the counter at 0; on any other press it SHALL enter IDLE.
REQ-017 In DELAY, each frame_tick with cur equal to prev SHALL increment the counter; when the counter reaches DAS_DELAY the block SHALL regenerate the held command, enter REPEAT and clear the counter.
REQ-018 In REPEAT, each frame_tick with cur equal to prev SHALL increment the counter; when it reaches DAS_RATE (Left/Right) or SOFT_RATE (Down) the block SHALL regenerate the command and clear the counter.
REQ-019 A frame_tick with cur = 0 SHALL return the FSM to IDLE and generate no command.
REQ-020 A change directly to another nonzero code SHALL be a new press event and SHALL restart the FSM per REQ-016.
REQ-021 A held A, B, Start or Up SHALL never repeat.
REQ-022 A generated command SHALL set cmd_valid and cmd in the clock cycle after frame_tick (latency 1).
REQ-023 cmd_valid and cmd SHALL remain stable until cmd_ready is high.
REQ-024 If a command is generated while cmd_valid is high and cmd_ready is low, the new command SHALL be discarded, the pending command kept, and cmd_dropped pulsed for one cycle.
REQ-025 If a command is generated in the same cycle that cmd_ready accepts the pending command, the new command SHALL load with no drop.
REQ-026 Counter arithmetic SHALL be 5-bit unsigned; the counter SHALL saturate and never wrap.
REQ-027 frame_tick SHALL be ignored while reset is high.

Reset
REQ-028 While reset is high, on the next clk edge cmd_valid SHALL become 0, cmd 0, cmd_dropped 0, the FSM IDLE, the counter 0 and prev 0.
REQ-029 Reset asserted mid-repeat or with a command pending SHALL discard all state; a button still held after reset SHALL count as a new press on the first frame_tick.

Structure
REQ-030 The command encoding, button code constants and default timing parameters SHALL live in the shared package tetris_input_pkg.
REQ-031 The frame counter and its terminal-count compare SHALL be one sub-module, das_timer; the remaining logic SHALL be in the top-level block.

Verification
REQ-032 Left (7) held for 30 ticks, cmd_ready tied high -> LEFT at ticks 0, 16, 22 and 28, and nothing else.
REQ-033 Down (6) held for 7 ticks -> SOFT_DROP at ticks 0, 2, 4 and 6.
REQ-034 A (1) held for 10 ticks, then 0, then A -> exactly two ROT_CW commands.
REQ-035 cmd_ready low, Up pressed, then B pressed on the next tick -> HARD_DROP held pending and cmd_dropped pulses once; raising cmd_ready accepts HARD_DROP only.
REQ-036 Left held 10 ticks then changed directly to Right -> RIGHT immediately, then the next RIGHT 16 ticks later.
REQ-037 Reset pulsed at tick 18 of a held Right, with the button still held -> cmd_valid 0 after the reset edge, and RIGHT at the first tick after reset.
